// File: rtl/wash_mode_select_if.sv
// Front-panel and run-controller signals of the program selector.
// The master drives the button/power/finish levels; the slave presents the program code.
interface wash_mode_select_if;
  logic       power_led;
  logic       start_pause;
  logic       module_select;
  logic       if_finish;
  logic [2:0] model_now;

  modport master (
    output power_led,
    output start_pause,
    output module_select,
    output if_finish,
    input  model_now
  );

  modport slave (
    input  power_led,
    input  start_pause,
    input  module_select,
    input  if_finish,
    output model_now
  );
endinterface

// File: rtl/wash_mode_select.sv
// Washing-machine program selector: power/run state tracking and program stepping
// from synchronized, edge-detected front-panel buttons. model_now is registered.
module wash_mode_select #(
  parameter int unsigned NUM_MODES    = 6,
  parameter int unsigned DEFAULT_MODE = 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               reset,
  wash_mode_select_if.slave  bus
);

  localparam int unsigned MODE_W = 3;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SELECT = 2'd1,
    ST_RUN    = 2'd2,
    ST_PAUSE  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [MODE_W-1:0]        mode_q, mode_d;
  logic [SYNC_STAGES-1:0]   sp_sync_q, ms_sync_q;
  logic                     sp_hist_q, ms_hist_q;
  logic                     sp_evt, ms_evt;

  // Button synchronizers and history flops keep running in every state,
  // so a button held through power-up never looks like a fresh press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_sync_q <= '0;
      ms_sync_q <= '0;
      sp_hist_q <= 1'b0;
      ms_hist_q <= 1'b0;
    end else begin
      sp_sync_q <= {sp_sync_q[SYNC_STAGES-2:0], bus.start_pause};
      ms_sync_q <= {ms_sync_q[SYNC_STAGES-2:0], bus.module_select};
      sp_hist_q <= sp_sync_q[SYNC_STAGES-1];
      ms_hist_q <= ms_sync_q[SYNC_STAGES-1];
    end
  end

  assign sp_evt = sp_sync_q[SYNC_STAGES-1] & ~sp_hist_q;
  assign ms_evt = ms_sync_q[SYNC_STAGES-1] & ~ms_hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_OFF;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Power loss dominates; start beats select when both fire in one cycle.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (!bus.power_led) begin
      state_d = ST_OFF;
      mode_d  = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_SELECT;
          mode_d  = MODE_W'(DEFAULT_MODE);
        end
        ST_SELECT: begin
          if (sp_evt) begin
            state_d = ST_RUN;
          end else if (ms_evt) begin
            mode_d = (mode_q == MODE_W'(NUM_MODES)) ? MODE_W'(1) : mode_q + MODE_W'(1);
          end
        end
        ST_RUN: begin
          if (bus.if_finish) begin
            state_d = ST_SELECT;
          end else if (sp_evt) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (bus.if_finish) begin
            state_d = ST_SELECT;
          end else if (sp_evt) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_OFF;
          mode_d  = '0;
        end
      endcase
    end
  end

  assign bus.model_now = mode_q;

endmodule

// File: tb/tb_wash_mode_select.sv
// Scoreboard bench for wash_mode_select: expected program codes are queued when a
// button action is driven and popped when the DUT is due to show the result.
`timescale 1ns/100ps
module tb_wash_mode_select;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [2:0] cur_exp;
  logic [2:0] exp_q[$];

  wash_mode_select_if bus();

  wash_mode_select #(
    .NUM_MODES    (6),
    .DEFAULT_MODE (1),
    .SYNC_STAGES  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #0.5;
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty"}, bus.model_now, 3'bxxx);
    end else begin
      e = exp_q.pop_front();
      chk(tag, bus.model_now, e);
      cur_exp = e;
    end
  endtask

  // Press one or both buttons; result must appear on the 3rd edge seeing the press.
  task automatic press(input logic sp, input logic ms, input logic [2:0] exp, input string tag);
    bus.start_pause   = sp;
    bus.module_select = ms;
    exp_q.push_back(exp);
    tick(2);
    chk({tag, "_early"}, bus.model_now, cur_exp);
    tick(1);
    pop_chk(tag);
    bus.start_pause   = 1'b0;
    bus.module_select = 1'b0;
    tick(5);
  endtask

  initial begin
    logic [2:0] step_exp;
    total = 0;
    bad   = 0;
    cur_exp = 3'd0;
    reset = 1'b0;
    bus.power_led     = 1'b1;
    bus.start_pause   = 1'b0;
    bus.module_select = 1'b0;
    bus.if_finish     = 1'b0;

    tick(3);
    chk("rst_hold", bus.model_now, 3'd0);
    reset = 1'b1;
    exp_q.push_back(3'd1);
    tick(1);
    pop_chk("power_up");

    // Step through all programs and wrap around.
    step_exp = 3'd1;
    for (int i = 0; i < 9; i++) begin
      step_exp = (step_exp == 3'd6) ? 3'd1 : step_exp + 3'd1;
      press(1'b0, 1'b1, step_exp, $sformatf("step%0d", i));
    end
    chk("at_four", bus.model_now, 3'd4);

    // Selection locked in RUN and PAUSE.
    press(1'b1, 1'b0, 3'd4, "start_run");
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 3'd4, $sformatf("run_lock%0d", i));
    press(1'b1, 1'b0, 3'd4, "pause");
    press(1'b0, 1'b1, 3'd4, "pause_lock");
    press(1'b1, 1'b0, 3'd4, "resume");

    // Finish returns to SELECT keeping the program.
    bus.if_finish = 1'b1;
    exp_q.push_back(3'd4);
    tick(1);
    bus.if_finish = 1'b0;
    pop_chk("finish");
    press(1'b0, 1'b1, 3'd5, "after_finish");

    // Power drop mid-run, re-power with select held.
    press(1'b1, 1'b0, 3'd5, "run2");
    bus.power_led = 1'b0;
    exp_q.push_back(3'd0);
    tick(1);
    pop_chk("power_drop");
    bus.module_select = 1'b1;
    tick(4);
    bus.power_led = 1'b1;
    exp_q.push_back(3'd1);
    tick(1);
    pop_chk("repower");
    tick(4);
    chk("held_no_step", bus.model_now, 3'd1);
    bus.module_select = 1'b0;
    tick(5);
    for (int i = 0; i < 5; i++) press(1'b0, 1'b1, 3'(i + 2), $sformatf("climb%0d", i));

    // Both events at mode 6: start wins.
    press(1'b1, 1'b1, 3'd6, "both_evt");
    press(1'b0, 1'b1, 3'd6, "both_is_run");
    press(1'b1, 1'b0, 3'd6, "pause2");

    // Start event coinciding with finish in PAUSE goes to SELECT.
    bus.start_pause = 1'b1;
    exp_q.push_back(3'd6);
    tick(2);
    bus.if_finish = 1'b1;
    tick(1);
    bus.if_finish = 1'b0;
    pop_chk("pause_finish");
    bus.start_pause = 1'b0;
    tick(5);
    press(1'b0, 1'b1, 3'd1, "wrap_in_select");

    // Asynchronous reset mid-run.
    press(1'b1, 1'b0, 3'd1, "run3");
    #0.3;
    reset = 1'b0;
    #0.2;
    chk("rst_async", bus.model_now, 3'd0);
    cur_exp = 3'd0;
    tick(2);
    reset = 1'b1;
    exp_q.push_back(3'd1);
    tick(1);
    pop_chk("rst_release");
    press(1'b0, 1'b1, 3'd2, "post_rst_sel");

    // Finish while in SELECT is ignored.
    bus.if_finish = 1'b1;
    press(1'b0, 1'b1, 3'd3, "finish_in_sel");
    bus.if_finish = 1'b0;

    if (exp_q.size() != 0) chk("queue_drain", 3'(exp_q.size()), 3'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
